// File: rtl/button_pkg.sv
// Shared constants and state encoding for consumers of the debounced button level.
package button_pkg;

   localparam int CLK_HZ            = 100_000_000;
   localparam int DEF_LONG_CYCLES   = CLK_HZ;
   localparam int DEF_REPEAT_CYCLES = CLK_HZ / 5;

   localparam logic [1:0] ST_LOCKOUT = 2'd0;
   localparam logic [1:0] ST_IDLE    = 2'd1;
   localparam logic [1:0] ST_PRESS   = 2'd2;
   localparam logic [1:0] ST_LONG    = 2'd3;

   typedef enum logic [1:0] {
      LOCKOUT = ST_LOCKOUT,
      IDLE    = ST_IDLE,
      PRESS   = ST_PRESS,
      LONG    = ST_LONG
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_event_hold_timer.sv
// Clearable saturating up-counter with a terminal-count compare, shared by the
// long-press and auto-repeat thresholds.
module hold_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [WIDTH-1:0] tc,
   output logic             at_tc
);

   logic [WIDTH-1:0] count;

   // Saturation matters only when repeats are disabled and LONG is held forever.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count != '1) begin
         count <= count + WIDTH'(1);
      end
   end

   assign at_tc = (count == tc);

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into press/click/long/repeat/release pulses
// plus a held level. release and repeat are SV keywords, hence the _pulse names.
module button_event
   import button_pkg::*;
#(
   parameter bit ACTIVE_HIGH   = 1'b1,
   parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter bit REPEAT_EN     = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic but_in,
   output logic press,
   output logic release_pulse,
   output logic click,
   output logic long_press,
   output logic repeat_pulse,
   output logic held
);

   localparam int CNT_W = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES) + 1);
   // The counter starts at 0 on the pulse cycle, so a threshold of N fires at N-1.
   localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic             INVERT    = ~ACTIVE_HIGH;

   state_t           state_q, state_d;
   logic             level_q;
   logic             press_d, release_d, click_d, long_d, repeat_d, held_d;
   logic             cnt_clear, at_tc;
   logic [CNT_W-1:0] cnt_tc;

   // level_q resets to "pressed" so a button held through reset stays locked out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q       <= 1'b1;
         state_q       <= LOCKOUT;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         click         <= 1'b0;
         long_press    <= 1'b0;
         repeat_pulse  <= 1'b0;
         held          <= 1'b0;
      end else begin
         level_q       <= but_in ^ INVERT;
         state_q       <= state_d;
         press         <= press_d;
         release_pulse <= release_d;
         click         <= click_d;
         long_press    <= long_d;
         repeat_pulse  <= repeat_d;
         held          <= held_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      click_d   = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      held_d    = held;
      cnt_clear = 1'b1;
      cnt_tc    = LONG_TC;
      unique case (state_q)
         LOCKOUT: begin
            if (!level_q) state_d = IDLE;
         end
         IDLE: begin
            if (level_q) begin
               state_d = PRESS;
               press_d = 1'b1;
               held_d  = 1'b1;
            end
         end
         PRESS: begin
            cnt_clear = 1'b0;
            // Release is tested first so it wins a collision with the threshold.
            if (!level_q) begin
               state_d   = IDLE;
               release_d = 1'b1;
               click_d   = 1'b1;
               held_d    = 1'b0;
               cnt_clear = 1'b1;
            end else if (at_tc) begin
               state_d   = LONG;
               long_d    = 1'b1;
               cnt_clear = 1'b1;
            end
         end
         LONG: begin
            cnt_clear = 1'b0;
            cnt_tc    = REPEAT_TC;
            if (!level_q) begin
               state_d   = IDLE;
               release_d = 1'b1;
               held_d    = 1'b0;
               cnt_clear = 1'b1;
            end else if (REPEAT_EN && at_tc) begin
               repeat_d  = 1'b1;
               cnt_clear = 1'b1;
            end
         end
         default: begin
            state_d = LOCKOUT;
         end
      endcase
   end

   hold_timer #(
      .WIDTH (CNT_W)
   ) u_hold_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (cnt_clear),
      .tc    (cnt_tc),
      .at_tc (at_tc)
   );

endmodule
